// File: rtl/mac.sv
// mac -- pipelined signed fixed-point multiply-accumulate (dot product).
//
// Computes round(sum(coefs[i] * pDataIn[i])) over NUM_REGS taps in
// Q(DATA_WIDTH-Q_FORMAT).Q_FORMAT format.
//   stage 1: full-precision products registered on an edge with inValid=1
//   stage 2: exact ACC_WIDTH sum, round half toward +inf, wrap to DATA_WIDTH
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   pDataIn    [0:NUM_REGS-1] signed samples
//   coefs      [0:NUM_REGS-1] signed coefficients
//   inValid    inputs valid this edge
//   macResult  registered result, holds between results
//   outValid   one-cycle pulse per accepted input, two register stages later

// Per-tap multiplier lane: holds its product while en is low.
module mac_lane #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           en,
   input  logic signed [DATA_WIDTH-1:0]   a,
   input  logic signed [DATA_WIDTH-1:0]   b,
   output logic signed [2*DATA_WIDTH-1:0] prod
);
   logic signed [2*DATA_WIDTH-1:0] a_ext, b_ext;

   assign a_ext = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
   assign b_ext = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  prod <= '0;
      else if (en) prod <= a_ext * b_ext;
   end
endmodule

module mac #(
   parameter int DATA_WIDTH = 32,
   parameter int Q_FORMAT   = 16,
   parameter int NUM_REGS   = 8,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(NUM_REGS)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic signed [DATA_WIDTH-1:0] pDataIn [0:NUM_REGS-1],
   input  logic signed [DATA_WIDTH-1:0] coefs   [0:NUM_REGS-1],
   input  logic                         inValid,
   output logic signed [DATA_WIDTH-1:0] macResult,
   output logic                         outValid
);
   localparam int PW = 2*DATA_WIDTH;

   logic signed [PW-1:0]        prod [0:NUM_REGS-1];
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] rounded;
   logic [1:0]                  vld_pipe;
   logic                        unused_bits;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_lane
         mac_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (inValid),
            .a    (coefs[gi]),
            .b    (pDataIn[gi]),
            .prod (prod[gi])
         );
      end
   endgenerate

   // Exact sum: ACC_WIDTH leaves room for NUM_REGS worst-case products.
   always_comb begin
      acc = '0;
      for (int i = 0; i < NUM_REGS; i++)
         acc = acc + {{(ACC_WIDTH-PW){prod[i][PW-1]}}, prod[i]};
   end

   // Adding half an LSB before the arithmetic shift rounds ties upward.
   assign rounded = acc + (ACC_WIDTH'(1) <<< (Q_FORMAT-1));

   // Bits above the output field wrap away; bits below are the rounded-off fraction.
   assign unused_bits = ^{rounded[ACC_WIDTH-1:Q_FORMAT+DATA_WIDTH], rounded[Q_FORMAT-1:0]};

   // vld_pipe[0]: products valid, vld_pipe[1]: result valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe  <= '0;
         macResult <= '0;
      end else begin
         vld_pipe <= {vld_pipe[0], inValid};
         if (vld_pipe[0]) macResult <= rounded[Q_FORMAT+DATA_WIDTH-1:Q_FORMAT];
      end
   end

   assign outValid = vld_pipe[1];
endmodule

// File: tb/tb_mac.sv
// tb_mac -- directed self-checking bench for mac (default parameters).
module tb_mac;
   localparam int DW = 32;
   localparam int N  = 8;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic signed [DW-1:0] pDataIn [0:N-1];
   logic signed [DW-1:0] coefs   [0:N-1];
   logic                 inValid = 1'b0;
   logic signed [DW-1:0] macResult;
   logic                 outValid;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mac dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pDataIn  (pDataIn),
      .coefs    (coefs),
      .inValid  (inValid),
      .macResult(macResult),
      .outValid (outValid)
   );

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic fill(input logic [DW-1:0] c, input logic [DW-1:0] d);
      for (int i = 0; i < N; i++) begin
         coefs[i]   = c;
         pDataIn[i] = d;
      end
   endtask

   // One accepted input, then step to the edge where its result is registered.
   task automatic run_one(input string tag, input logic [DW-1:0] exp);
      inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      check({tag, "_ov_s1"}, {31'd0, outValid}, 32'd0);
      @(posedge clk); #1;
      check({tag, "_ov"}, {31'd0, outValid}, 32'd1);
      check({tag, "_res"}, macResult, exp);
      @(posedge clk); #1;
      check({tag, "_ov_off"}, {31'd0, outValid}, 32'd0);
   endtask

   int tv [0:3][0:N-1];
   logic [DW-1:0] exp_s [0:3];
   int sum;
   int seen;

   initial begin
      fill(32'h0, 32'h0);
      #2;
      check("rst_res", macResult, 32'd0);
      check("rst_ov", {31'd0, outValid}, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      fill(32'h0001_0000, 32'h0003_0000);
      run_one("ones", 32'h0018_0000);

      fill(32'h0000_3333, 32'h000A_0000);
      run_one("p2x10", 32'h000F_FFF0);
      fill(32'h0000_3333, 32'hFFFB_0000);
      run_one("p2xm5", 32'hFFF8_0008);

      // Hold: no new input, result and valid stay put.
      repeat (3) @(posedge clk);
      #1;
      check("hold_res", macResult, 32'hFFF8_0008);
      check("hold_ov", {31'd0, outValid}, 32'd0);

      fill(32'h0, 32'h0);
      coefs[0] = 32'h0000_0001; pDataIn[0] = 32'h0000_8000;
      run_one("rnd_up", 32'h0000_0001);
      pDataIn[0] = 32'hFFFF_8000;
      run_one("rnd_neg", 32'h0000_0000);

      fill(32'h0001_0000, 32'h7FFF_FFFF);
      run_one("wrap", 32'hFFFF_FFF8);

      // Tap order: (i+1)*1.0 vs 1.0*(8-i) both sum to 36.0.
      for (int i = 0; i < N; i++) begin
         coefs[i] = (i+1) << 16; pDataIn[i] = 32'h0001_0000;
      end
      run_one("ord_a", 32'h0024_0000);
      for (int i = 0; i < N; i++) begin
         coefs[i] = 32'h0001_0000; pDataIn[i] = (N-i) << 16;
      end
      run_one("ord_b", 32'h0024_0000);

      // Back-to-back stream; integer taps times 0x199A give 0x199A*sum exactly.
      for (int k = 0; k < 4; k++) begin
         sum = 0;
         for (int i = 0; i < N; i++) begin
            tv[k][i] = $urandom_range(50, 1);
            sum += tv[k][i];
         end
         exp_s[k] = 32'(6554 * sum);
      end
      for (int k = 0; k < 6; k++) begin
         if (k < 4) begin
            inValid = 1'b1;
            for (int i = 0; i < N; i++) begin
               coefs[i] = 32'h0000_199A; pDataIn[i] = tv[k][i] << 16;
            end
         end else inValid = 1'b0;
         @(posedge clk); #1;
         if (k >= 1 && k <= 4) begin
            check($sformatf("strm%0d_ov", k-1), {31'd0, outValid}, 32'd1);
            check($sformatf("strm%0d_res", k-1), macResult, exp_s[k-1]);
         end
      end
      inValid = 1'b0;
      @(posedge clk); #1;
      check("strm_end_ov", {31'd0, outValid}, 32'd0);

      // Reset one cycle after an accepted input.
      fill(32'h0001_0000, 32'h0003_0000);
      inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("arst_res", macResult, 32'd0);
      check("arst_ov", {31'd0, outValid}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      seen = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (outValid) seen++;
      end
      check("arst_stale", 32'(seen), 32'd0);
      check("arst_res_after", macResult, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
